// File: rtl/sequenciador_quadros_pkg.sv
// Shared definitions for the pet animation frame sequencer.
// Holds the pet state encoding, the sequencer FSM states and the
// image ROM address layout {estado, quadro, byte}.
package sequenciador_quadros_pkg;

    // Pet states as seen on the estado input; 5..15 are not states.
    typedef enum logic [2:0] {
        EST_IDLE       = 3'd0,
        EST_DORMINDO   = 3'd1,
        EST_COMENDO    = 3'd2,
        EST_DANDO_AULA = 3'd3,
        EST_MORTO      = 3'd4
    } estado_t;

    // Sequencer FSM: wait for a request, read one byte, present it, close the frame.
    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        LE     = 2'd1,
        ENVIA  = 2'd2,
        FIM    = 2'd3
    } fsm_t;

    // One 128x64 monochrome page buffer.
    localparam int N_BYTES_QUADRO = 1024;

    // Width of the estado input and of the estado field inside the ROM address.
    localparam int W_ESTADO_IN    = 4;
    localparam int W_CAMPO_ESTADO = 3;

    // Full ROM address width for a given frame count and frame size.
    function automatic int largura_endereco(input int n_quadros, input int n_bytes);
        return W_CAMPO_ESTADO + $clog2(n_quadros) + $clog2(n_bytes);
    endfunction

    // Only IDLE..MORTO are real pet states.
    function automatic logic estado_valido(input logic [W_ESTADO_IN-1:0] e);
        return e <= {1'b0, EST_MORTO};
    endfunction

endpackage

// File: rtl/sequenciador_quadros_contador_quadro.sv
// Animation frame counter for the current pet state.
// Latency: new value visible the cycle after a tick or state change.
// No backpressure: it follows requests as they arrive, even mid-frame.
module sequenciador_quadros_contador_quadro #(
    parameter int N_QUADROS = 2,
    parameter int W_Q       = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_avanca,
    input  logic           i_zera,
    output logic [W_Q-1:0] o_quadro
);

    localparam logic [W_Q-1:0] ULTIMO_QUADRO = W_Q'(N_QUADROS - 1);

    logic [W_Q-1:0] r_quadro;

    // A state change restarts the animation and wins over a simultaneous tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quadro <= '0;
        end else if (i_zera) begin
            r_quadro <= '0;
        end else if (i_avanca) begin
            r_quadro <= (r_quadro == ULTIMO_QUADRO) ? '0 : r_quadro + 1'b1;
        end
    end

    assign o_quadro = r_quadro;

endmodule

// File: rtl/sequenciador_quadros.sv
// Streams one animation frame of the current pet state from an external image ROM to the display.
// Latency: one byte every 2 cycles when pronto is high; fim_quadro 2*N_BYTES cycles after the first read.
// Backpressure: pronto low freezes dado_out/valido; requests arriving mid-frame are merged and served after it.
module sequenciador_quadros
    import sequenciador_quadros_pkg::*;
#(
    parameter int N_QUADROS = 2,
    parameter int N_BYTES   = N_BYTES_QUADRO
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [W_ESTADO_IN-1:0]                          estado,
    input  logic                                            tick_quadro,
    output logic [largura_endereco(N_QUADROS, N_BYTES)-1:0] mem_addr,
    output logic                                            mem_en,
    input  logic [7:0]                                      mem_dado,
    output logic [7:0]                                      dado_out,
    output logic                                            valido,
    input  logic                                            pronto,
    output logic                                            inicio_quadro,
    output logic                                            fim_quadro,
    output logic                                            ocupado
);

    localparam int W_Q   = $clog2(N_QUADROS);
    localparam int W_QI  = (W_Q > 0) ? W_Q : 1;
    localparam int W_IDX = $clog2(N_BYTES);
    localparam logic [W_IDX-1:0] ULTIMO_BYTE = W_IDX'(N_BYTES - 1);

    // Request tracking (runs independently of the frame in flight)
    estado_t          r_estado_atual;
    logic             r_pendente;
    logic [W_QI-1:0]  w_quadro;
    logic             w_mudanca;
    logic             w_pedido;

    // Frame in flight
    fsm_t             r_fsm;
    estado_t          r_cap_estado;
    logic [W_QI-1:0]  r_cap_quadro;
    logic [W_IDX-1:0] r_idx;
    logic             r_mem_en;
    logic             r_valido;
    logic             r_primeiro;
    logic [7:0]       r_dado;
    logic             r_inicio;
    logic             r_fim;
    logic             r_ocupado;
    logic             w_ultimo;

    // Out-of-range estado values never count as a change.
    assign w_mudanca = estado_valido(estado) && (estado[2:0] != r_estado_atual);
    assign w_pedido  = tick_quadro || w_mudanca;
    assign w_ultimo  = (r_idx == ULTIMO_BYTE);

    sequenciador_quadros_contador_quadro #(
        .N_QUADROS (N_QUADROS),
        .W_Q       (W_QI)
    ) u_contador_quadro (
        .clk      (clk),
        .reset    (reset),
        .i_avanca (tick_quadro),
        .i_zera   (w_mudanca),
        .o_quadro (w_quadro)
    );

    // Track the last valid pet state; the reset state is IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado_atual <= EST_IDLE;
        end else if (w_mudanca) begin
            r_estado_atual <= estado_t'(estado[2:0]);
        end
    end

    // One pending flag absorbs any number of requests; a request arriving on
    // the same cycle a frame starts survives so it is rendered afterwards.
    // Reset leaves it set so the IDLE frame is drawn without any stimulus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pendente <= 1'b1;
        end else if (w_pedido) begin
            r_pendente <= 1'b1;
        end else if (r_pendente && (r_fsm == ESPERA || r_fsm == FIM)) begin
            r_pendente <= 1'b0;
        end
    end

    // Frame sequencer: capture state/frame, then alternate ROM read and byte handoff.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= ESPERA;
            r_cap_estado <= EST_IDLE;
            r_cap_quadro <= '0;
            r_idx        <= '0;
            r_mem_en     <= 1'b0;
            r_valido     <= 1'b0;
            r_primeiro   <= 1'b0;
            r_dado       <= '0;
            r_inicio     <= 1'b0;
            r_fim        <= 1'b0;
            r_ocupado    <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_primeiro <= 1'b0;
            r_inicio   <= 1'b0;
            r_fim      <= 1'b0;
            case (r_fsm)
                ESPERA, FIM: begin
                    if (r_pendente) begin
                        // Freeze what this frame shows; later requests only touch the trackers.
                        r_fsm        <= LE;
                        r_cap_estado <= r_estado_atual;
                        r_cap_quadro <= w_quadro;
                        r_idx        <= '0;
                        r_mem_en     <= 1'b1;
                        r_ocupado    <= 1'b1;
                    end else if (r_fsm == FIM) begin
                        r_fsm     <= ESPERA;
                        r_ocupado <= 1'b0;
                    end
                end
                LE: begin
                    r_fsm      <= ENVIA;
                    r_valido   <= 1'b1;
                    r_primeiro <= 1'b1;
                    r_inicio   <= (r_idx == '0);
                end
                ENVIA: begin
                    // ROM data only lives for one cycle, so keep a copy for stalls.
                    if (r_primeiro) begin
                        r_dado <= mem_dado;
                    end
                    if (pronto) begin
                        r_valido <= 1'b0;
                        if (w_ultimo) begin
                            r_fsm <= FIM;
                            r_idx <= '0;
                            r_fim <= 1'b1;
                        end else begin
                            r_fsm    <= LE;
                            r_idx    <= r_idx + 1'b1;
                            r_mem_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_fsm <= ESPERA;
                end
            endcase
        end
    end

    // Address is built from registers only, so it is steady for the whole read cycle.
    generate
        if (W_Q == 0) begin : g_sem_quadro
            assign mem_addr = {r_cap_estado, r_idx};
        end else begin : g_com_quadro
            assign mem_addr = {r_cap_estado, r_cap_quadro, r_idx};
        end
    endgenerate

    // First ENVIA cycle passes the ROM byte straight through; after that the held copy.
    assign dado_out      = r_primeiro ? mem_dado : r_dado;
    assign mem_en        = r_mem_en;
    assign valido        = r_valido;
    assign inicio_quadro = r_inicio;
    assign fim_quadro    = r_fim;
    assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_sequenciador_quadros.sv
// Self-checking bench: frame scoreboard of expected ROM bases, byte-by-byte compare,
// handshake stability under stalls, frame timing, request merging and mid-frame reset.
module tb_sequenciador_quadros;
    import sequenciador_quadros_pkg::*;

    localparam int NQ = 2;
    localparam int NB = 1024;
    localparam int WQ = $clog2(NQ);
    localparam int WB = $clog2(NB);
    localparam int WA = largura_endereco(NQ, NB);
    localparam int LIMITE = 20000;

    logic          clk;
    logic          reset;
    logic [3:0]    estado;
    logic          tick_quadro;
    logic [WA-1:0] mem_addr;
    logic          mem_en;
    logic [7:0]    mem_dado;
    logic [7:0]    dado_out;
    logic          valido;
    logic          pronto;
    logic          inicio_quadro;
    logic          fim_quadro;
    logic          ocupado;

    int n_checks = 0;
    int n_erros  = 0;
    int cyc      = 0;
    int q_base[$];

    int         m_idx = 0;
    int         m_t_le = 0;
    int         n_quadros = 0;
    bit         m_fim_esp = 0;
    bit         m_prev_stall = 0;
    bit         m_prev_valido = 0;
    bit         m_sem_stall = 0;
    logic [7:0] m_prev_dado = '0;

    bit stall_armado = 0;
    int stall_byte   = 0;
    int stall_cnt    = 0;
    bit bp_aleatorio = 0;

    sequenciador_quadros #(.N_QUADROS(NQ), .N_BYTES(NB)) dut (
        .clk           (clk),
        .reset         (reset),
        .estado        (estado),
        .tick_quadro   (tick_quadro),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .mem_dado      (mem_dado),
        .dado_out      (dado_out),
        .valido        (valido),
        .pronto        (pronto),
        .inicio_quadro (inicio_quadro),
        .fim_quadro    (fim_quadro),
        .ocupado       (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int base(input int e, input int q);
        return (e << (WQ + WB)) | (q << WB);
    endfunction

    // Image content: depends on every address bit so a wrong field shows up.
    function automatic logic [7:0] rom(input int a);
        return 8'((a & 255) + (a >> 8) * 29 + 7);
    endfunction

    // Synchronous ROM: data valid only the cycle after mem_en, junk otherwise.
    always @(posedge clk) mem_dado <= mem_en ? rom(int'(mem_addr)) : 8'hEE;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", tag, obs, esp, cyc);
        end
    endtask

    // Monitor: compares addresses, bytes, pulses and stall stability against the frame queue.
    always @(negedge clk) begin
        if (reset) begin
            m_idx         = 0;
            m_fim_esp     = 0;
            m_prev_stall  = 0;
            m_prev_valido = 0;
        end else begin
            if (fim_quadro || m_fim_esp) begin
                verifica("fim_quadro", 32'(fim_quadro), 32'(m_fim_esp));
                if (m_fim_esp && m_sem_stall)
                    verifica("latencia_quadro", 32'(cyc - m_t_le), 32'(2 * NB));
            end
            m_fim_esp = 0;
            if (m_prev_stall)
                verifica("estavel", 32'({valido, dado_out}), 32'({1'b1, m_prev_dado}));
            if (mem_en) begin
                if (q_base.size() == 0) begin
                    verifica("quadro_inesperado", 32'(mem_en), 32'(0));
                end else begin
                    if (m_idx == 0) begin
                        m_t_le      = cyc;
                        m_sem_stall = 1;
                    end
                    verifica("mem_addr", 32'(mem_addr), 32'(q_base[0] + m_idx));
                end
            end
            if (valido && !m_prev_valido && m_idx == 0)
                verifica("inicio_quadro", 32'(inicio_quadro), 32'(1));
            else if (inicio_quadro)
                verifica("inicio_quadro_extra", 32'(inicio_quadro), 32'(0));
            if (valido && pronto && q_base.size() != 0) begin
                verifica("dado_out", 32'(dado_out), 32'(rom(q_base[0] + m_idx)));
                m_idx++;
                if (m_idx == NB) begin
                    m_idx = 0;
                    void'(q_base.pop_front());
                    m_fim_esp = 1;
                    n_quadros++;
                end
            end
            m_prev_stall = valido && !pronto;
            if (m_prev_stall) m_sem_stall = 0;
            m_prev_dado   = dado_out;
            m_prev_valido = valido;
        end
    end

    // Display driver model: ready by default, scripted stall or random backpressure.
    initial begin
        pronto = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_armado && valido && m_idx == stall_byte) begin
                pronto = 1'b0;
                stall_cnt++;
                if (stall_cnt == 5) stall_armado = 0;
            end else if (bp_aleatorio) begin
                pronto = 1'($urandom_range(0, 1));
            end else begin
                pronto = 1'b1;
            end
        end
    end

    task automatic pulso(input logic [3:0] e, input logic t);
        @(posedge clk);
        #1;
        estado      = e;
        tick_quadro = t;
        @(posedge clk);
        #1;
        tick_quadro = 1'b0;
    endtask

    task automatic aguarda_fim(input string tag);
        int c = 0;
        while ((q_base.size() != 0 || ocupado) && c < LIMITE) begin
            @(posedge clk);
            c++;
        end
        verifica(tag, 32'(c < LIMITE), 32'(1));
    endtask

    task automatic espera_idx(input string tag, input int alvo);
        int c = 0;
        while (!(q_base.size() == 1 && m_idx == alvo) && c < LIMITE) begin
            @(posedge clk);
            c++;
        end
        verifica(tag, 32'(c < LIMITE), 32'(1));
    endtask

    initial begin
        int n0;
        reset       = 1'b1;
        estado      = 4'd0;
        tick_quadro = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        verifica("rst_valido", 32'(valido), 32'(0));
        verifica("rst_mem_en", 32'(mem_en), 32'(0));
        verifica("rst_dado_out", 32'(dado_out), 32'(0));
        verifica("rst_inicio", 32'(inicio_quadro), 32'(0));
        verifica("rst_fim", 32'(fim_quadro), 32'(0));
        verifica("rst_ocupado", 32'(ocupado), 32'(0));
        verifica("rst_mem_addr", 32'(mem_addr), 32'(0));

        // IDLE frame rendered right after reset with no request
        q_base.push_back(base(0, 0));
        reset = 1'b0;
        aguarda_fim("fim_idle");
        verifica("quadros_idle", 32'(n_quadros), 32'(1));

        // COMENDO: change together with a tick gives quadro 0, then ticks give 1 and 0
        q_base.push_back(base(2, 0));
        pulso(4'd2, 1'b1);
        aguarda_fim("fim_comendo_q0");
        stall_byte   = 17;
        stall_cnt    = 0;
        stall_armado = 1;
        q_base.push_back(base(2, 1));
        pulso(4'd2, 1'b1);
        aguarda_fim("fim_comendo_q1");
        verifica("stall_aplicado", 32'(stall_cnt), 32'(5));
        q_base.push_back(base(2, 0));
        pulso(4'd2, 1'b1);
        aguarda_fim("fim_comendo_q0b");
        verifica("quadros_comendo", 32'(n_quadros), 32'(4));

        // DORMINDO frame, switch to DANDO_AULA mid-frame, then two merged ticks
        q_base.push_back(base(1, 0));
        pulso(4'd1, 1'b0);
        espera_idx("espera_byte500", 500);
        q_base.push_back(base(3, 0));
        pulso(4'd3, 1'b0);
        espera_idx("espera_aula", 100);
        q_base.push_back(base(3, 0));
        pulso(4'd3, 1'b1);
        repeat (7) @(posedge clk);
        pulso(4'd3, 1'b1);
        aguarda_fim("fim_aula");
        repeat (40) @(posedge clk);
        #1;
        verifica("quadros_mesclados", 32'(n_quadros), 32'(7));
        verifica("ocioso", 32'(ocupado), 32'(0));

        // Invalid estado is ignored; then tick + change in the same cycle, random backpressure
        n0 = n_quadros;
        pulso(4'd9, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        verifica("estado_invalido", 32'(n_quadros), 32'(n0));
        verifica("addr_mantido", 32'(mem_addr), 32'(base(3, 0)));
        verifica("ocupado_invalido", 32'(ocupado), 32'(0));
        q_base.push_back(base(4, 0));
        bp_aleatorio = 1;
        pulso(4'd4, 1'b1);
        aguarda_fim("fim_morto");
        bp_aleatorio = 0;
        verifica("quadro_unico", 32'(n_quadros), 32'(n0 + 1));

        // Reset at byte 300 aborts the frame; a fresh IDLE frame follows
        q_base.push_back(base(1, 0));
        pulso(4'd1, 1'b0);
        espera_idx("espera_byte300", 300);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        estado = 4'd0;
        @(posedge clk);
        #1;
        verifica("valido_pos_reset", 32'(valido), 32'(0));
        verifica("mem_en_pos_reset", 32'(mem_en), 32'(0));
        verifica("ocupado_pos_reset", 32'(ocupado), 32'(0));
        verifica("fim_pos_reset", 32'(fim_quadro), 32'(0));
        n0 = n_quadros;
        q_base.delete();
        q_base.push_back(base(0, 0));
        reset = 1'b0;
        aguarda_fim("fim_pos_reset");
        verifica("quadro_pos_reset", 32'(n_quadros), 32'(n0 + 1));
        verifica("fila_vazia", 32'(q_base.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulacao sem termino, ciclo=%0d esperado<60000", cyc);
        $fatal(1);
    end

endmodule
